// File: rtl/ddr_app_pkg.sv
// Shared types for the DDR app-interface read/write arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr_app_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

endpackage

// File: rtl/ddr_wdf_beat_ctrl.sv
// Write-data beat engine: tracks beats owed to the controller and streams them from the wdata FWFT head.
// Latency: combinational from FIFO head to app_wdf_*; credit/beat counters update on the next edge.
// Backpressure: a beat is held on app_wdf_* until app_wdf_rdy; no beat is offered while nothing is owed.
module ddr_wdf_beat_ctrl
    import ddr_app_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int BEATS      = 2,
    parameter int CREDIT_MAX = 8,
    localparam int CW        = $clog2(CREDIT_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] wdata_fifo_dout,
    input  logic              wdata_fifo_empty,
    input  logic              app_wdf_rdy,
    output logic              wdata_fifo_rd_en,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [CW-1:0]     credit,
    output logic [CW-1:0]     credit_nxt
);

    localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);

    logic [BCW-1:0] beat_cnt;
    logic           beat;

    assign app_wdf_wren     = (credit != '0) && !wdata_fifo_empty;
    assign app_wdf_data     = wdata_fifo_dout;
    assign beat             = app_wdf_wren && app_wdf_rdy;
    assign wdata_fifo_rd_en = beat;
    assign app_wdf_end      = app_wdf_wren && (beat_cnt == BEAT_LAST);

    // Beats owed after this cycle: a new command adds a burst, an accepted beat retires one.
    always_comb begin
        credit_nxt = credit;
        if (issue) begin
            credit_nxt = credit_nxt + CW'(BEATS);
        end
        if (beat) begin
            credit_nxt = credit_nxt - CW'(1);
        end
    end

    // Credit and position-in-burst registers; reset abandons any partial burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit   <= '0;
            beat_cnt <= '0;
        end else begin
            credit <= credit_nxt;
            if (beat) begin
                beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_app_rw_arb.sv
// Read/write arbiter between user FWFT FIFOs and a MIG-style app interface, with hysteresis and grant limit.
// Latency: one cycle IDLE->RD/WR, TURN_CYC dead cycles on a direction change, then one command per cycle.
// Backpressure: command held stable until app_rdy; reads stall on rdata_fifo_afull; writes stall on credit.
module ddr_app_rw_arb
    import ddr_app_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 29,
    parameter int BEATS      = 2,
    parameter int DEPTH_W    = 9,
    parameter int SWH        = 384,
    parameter int SWL        = 128,
    parameter int TURN_CYC   = 3,
    parameter int MAX_GRANT  = 64,
    parameter int CREDIT_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   raddr_fifo_dout,
    input  logic                raddr_fifo_empty,
    output logic                raddr_fifo_rd_en,
    input  logic                rdata_fifo_afull,
    output logic [DATA_W-1:0]   rdata_fifo_din,
    output logic                rdata_fifo_wr_en,
    input  logic [ADDR_W-1:0]   waddr_fifo_dout,
    input  logic                waddr_fifo_empty,
    output logic                waddr_fifo_rd_en,
    input  logic [DATA_W-1:0]   wdata_fifo_dout,
    input  logic                wdata_fifo_empty,
    output logic                wdata_fifo_rd_en,
    input  logic [DEPTH_W-1:0]  wdata_fifo_rdepth,
    input  logic                app_rdy,
    input  logic                app_wdf_rdy,
    input  logic                app_rd_data_valid,
    input  logic [DATA_W-1:0]   app_rd_data,
    output logic                app_en,
    output logic [2:0]          app_cmd,
    output logic [ADDR_W-1:0]   app_addr,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic [DATA_W/8-1:0] app_wdf_mask
);

    localparam int CREDIT_W = $clog2(CREDIT_MAX + 1);
    localparam int GW       = $clog2(MAX_GRANT + 1);
    localparam int TW       = 4;

    localparam logic [DEPTH_W-1:0]  D_BEATS    = DEPTH_W'(BEATS);
    localparam logic [DEPTH_W-1:0]  D_SWH      = DEPTH_W'(SWH);
    localparam logic [DEPTH_W-1:0]  D_SWL      = DEPTH_W'(SWL);
    localparam logic [CREDIT_W-1:0] CREDIT_LIM = CREDIT_W'(CREDIT_MAX - BEATS);
    localparam logic [GW-1:0]       G_MAX      = GW'(MAX_GRANT);
    localparam logic [TW-1:0]       T_LAST     = TW'(TURN_CYC - 1);

    arb_state_t          state, state_nxt;
    arb_state_t          dir_tgt, dir_tgt_nxt;
    logic [GW-1:0]       grant_cnt;
    logic [TW-1:0]       turn_cnt;
    logic [CREDIT_W-1:0] credit, credit_nxt;

    logic wr_ok, rd_pend, grant_full, rd_stop, wr_stop, hold;

    // A write is worth issuing only when a full burst of data is already buffered.
    assign wr_ok      = !waddr_fifo_empty && (wdata_fifo_rdepth >= D_BEATS);
    assign rd_pend    = !raddr_fifo_empty;
    assign grant_full = (grant_cnt == G_MAX);
    // Once the grant is used up and the other side waits, stop issuing so the switch can happen.
    assign rd_stop    = wr_ok && grant_full;
    assign wr_stop    = rd_pend && ((wdata_fifo_rdepth <= D_SWL) || grant_full);
    assign hold       = app_en && !app_rdy;

    assign rdata_fifo_din   = app_rd_data;
    assign rdata_fifo_wr_en = app_rd_data_valid;
    assign app_wdf_mask     = '0;

    // Next-state and command-path decode; a command awaiting app_rdy pins the state.
    always_comb begin
        state_nxt        = state;
        dir_tgt_nxt      = dir_tgt;
        app_en           = 1'b0;
        app_cmd          = CMD_WR;
        app_addr         = '0;
        raddr_fifo_rd_en = 1'b0;
        waddr_fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (wr_ok) begin
                    state_nxt = WR;
                end else if (rd_pend) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                app_en           = rd_pend && !rdata_fifo_afull && !rd_stop;
                app_cmd          = CMD_RD;
                app_addr         = raddr_fifo_dout;
                raddr_fifo_rd_en = app_en && app_rdy;
                if (!hold) begin
                    if (!rd_pend && waddr_fifo_empty) begin
                        state_nxt = IDLE;
                    end else if (wr_ok && ((wdata_fifo_rdepth >= D_SWH) || !rd_pend || grant_full)) begin
                        state_nxt   = TURN;
                        dir_tgt_nxt = WR;
                    end
                end
            end
            WR: begin
                app_en           = wr_ok && (credit <= CREDIT_LIM) && !wr_stop;
                app_cmd          = CMD_WR;
                app_addr         = waddr_fifo_dout;
                waddr_fifo_rd_en = app_en && app_rdy;
                if (!hold) begin
                    if (!rd_pend && waddr_fifo_empty) begin
                        state_nxt = IDLE;
                    end else if ((credit_nxt == '0) && rd_pend &&
                                 ((wdata_fifo_rdepth <= D_SWL) || waddr_fifo_empty || grant_full)) begin
                        state_nxt   = TURN;
                        dir_tgt_nxt = RD;
                    end
                end
            end
            TURN: begin
                if (turn_cnt == T_LAST) begin
                    state_nxt = dir_tgt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, turnaround timer and per-direction grant counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir_tgt   <= RD;
            grant_cnt <= '0;
            turn_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            dir_tgt <= dir_tgt_nxt;
            if (state_nxt != state) begin
                grant_cnt <= '0;
            end else if (app_en && app_rdy && !grant_full) begin
                grant_cnt <= grant_cnt + 1'b1;
            end
            if (state != TURN) begin
                turn_cnt <= '0;
            end else begin
                turn_cnt <= turn_cnt + 1'b1;
            end
        end
    end

    ddr_wdf_beat_ctrl #(
        .DATA_W     (DATA_W),
        .BEATS      (BEATS),
        .CREDIT_MAX (CREDIT_MAX)
    ) u_wdf (
        .clk              (clk),
        .rst              (rst),
        .issue            (waddr_fifo_rd_en),
        .wdata_fifo_dout  (wdata_fifo_dout),
        .wdata_fifo_empty (wdata_fifo_empty),
        .app_wdf_rdy      (app_wdf_rdy),
        .wdata_fifo_rd_en (wdata_fifo_rd_en),
        .app_wdf_wren     (app_wdf_wren),
        .app_wdf_end      (app_wdf_end),
        .app_wdf_data     (app_wdf_data),
        .credit           (credit),
        .credit_nxt       (credit_nxt)
    );

endmodule

// File: tb/tb_ddr_app_rw_arb.sv
// Directed bench for ddr_app_rw_arb with FWFT FIFO models and a command/beat log.
// Latency: n/a.
// Backpressure: app_rdy / app_wdf_rdy driven by the stimulus.
module tb_ddr_app_rw_arb;
    import ddr_app_pkg::*;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 29;
    localparam int DEPTH_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0]   raddr_fifo_dout = '0;
    logic                raddr_fifo_empty = 1'b1;
    logic                raddr_fifo_rd_en;
    logic                rdata_fifo_afull;
    logic [DATA_W-1:0]   rdata_fifo_din;
    logic                rdata_fifo_wr_en;
    logic [ADDR_W-1:0]   waddr_fifo_dout = '0;
    logic                waddr_fifo_empty = 1'b1;
    logic                waddr_fifo_rd_en;
    logic [DATA_W-1:0]   wdata_fifo_dout = '0;
    logic                wdata_fifo_empty = 1'b1;
    logic                wdata_fifo_rd_en;
    logic [DEPTH_W-1:0]  wdata_fifo_rdepth;
    logic                app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_en;
    logic [2:0]          app_cmd;
    logic [ADDR_W-1:0]   app_addr;
    logic                app_wdf_wren, app_wdf_end;
    logic [DATA_W-1:0]   app_wdf_data;
    logic [DATA_W/8-1:0] app_wdf_mask;

    ddr_app_rw_arb dut (
        .clk               (clk),
        .rst               (rst),
        .raddr_fifo_dout   (raddr_fifo_dout),
        .raddr_fifo_empty  (raddr_fifo_empty),
        .raddr_fifo_rd_en  (raddr_fifo_rd_en),
        .rdata_fifo_afull  (rdata_fifo_afull),
        .rdata_fifo_din    (rdata_fifo_din),
        .rdata_fifo_wr_en  (rdata_fifo_wr_en),
        .waddr_fifo_dout   (waddr_fifo_dout),
        .waddr_fifo_empty  (waddr_fifo_empty),
        .waddr_fifo_rd_en  (waddr_fifo_rd_en),
        .wdata_fifo_dout   (wdata_fifo_dout),
        .wdata_fifo_empty  (wdata_fifo_empty),
        .wdata_fifo_rd_en  (wdata_fifo_rd_en),
        .wdata_fifo_rdepth (wdata_fifo_rdepth),
        .app_rdy           (app_rdy),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data       (app_rd_data),
        .app_en            (app_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask      (app_wdf_mask)
    );

    typedef struct packed {
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       cyc;
    } cmd_rec_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [31:0]       cyc;
    } beat_rec_t;

    logic [ADDR_W-1:0] rq[$], wq[$], rexp[$], wexp[$];
    logic [DATA_W-1:0] dq[$], dexp[$];
    cmd_rec_t          cmd_log[$];
    beat_rec_t         wdf_log[$];
    int                run_len[$];
    logic [2:0]        run_cmd[$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   turn_seen = 0;
    logic pop_r = 1'b0, pop_w = 1'b0, pop_d = 1'b0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle counter used to timestamp the logs.
    always @(posedge clk) cyc <= cyc + 1;

    // FWFT FIFO models: apply the pops the DUT requested, then present the new heads.
    always @(posedge clk) begin
        #1;
        if (pop_r && rq.size() > 0) void'(rq.pop_front());
        if (pop_w && wq.size() > 0) void'(wq.pop_front());
        if (pop_d && dq.size() > 0) void'(dq.pop_front());
        raddr_fifo_empty = (rq.size() == 0);
        raddr_fifo_dout  = raddr_fifo_empty ? '0 : rq[0];
        waddr_fifo_empty = (wq.size() == 0);
        waddr_fifo_dout  = waddr_fifo_empty ? '0 : wq[0];
        wdata_fifo_empty = (dq.size() == 0);
        wdata_fifo_dout  = wdata_fifo_empty ? '0 : dq[0];
    end

    // Mid-cycle monitor: log accepted commands and beats, latch FIFO pops.
    always @(negedge clk) begin
        if (!rst) begin
            if (app_en && app_rdy) cmd_log.push_back({app_cmd, app_addr, 32'(cyc)});
            if (app_wdf_wren && app_wdf_rdy) wdf_log.push_back({app_wdf_data, app_wdf_end, 32'(cyc)});
            if (dut.state == TURN) turn_seen++;
        end
        pop_r = raddr_fifo_rd_en;
        pop_w = waddr_fifo_rd_en;
        pop_d = wdata_fifo_rd_en;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_r(input int a);
        rq.push_back(ADDR_W'(a));
        rexp.push_back(ADDR_W'(a));
    endtask

    task automatic push_w(input int a, input int d0);
        wq.push_back(ADDR_W'(a));
        wexp.push_back(ADDR_W'(a));
        for (int b = 0; b < 2; b++) begin
            dq.push_back({(DATA_W/32){32'(d0 * 2 + b)}});
            dexp.push_back({(DATA_W/32){32'(d0 * 2 + b)}});
        end
    endtask

    task automatic clear_logs();
        cmd_log.delete(); wdf_log.delete();
        rexp.delete(); wexp.delete(); dexp.delete();
        turn_seen = 0;
    endtask

    task automatic wait_cmds(input int n, input int budget, input string tag);
        int k = 0;
        while (cmd_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (cmd_log.size() < n) check_eq({tag, " cmd timeout"}, DATA_W'(cmd_log.size()), DATA_W'(n));
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int   k = 0;
        logic quiet = 1'b0;
        while (!quiet && k < budget) begin
            tick();
            k++;
            quiet = (rq.size() == 0) && (wq.size() == 0) && (dq.size() == 0) &&
                    (dut.state == IDLE) && (dut.u_wdf.credit == 0);
        end
        check_eq({tag, " drained"}, DATA_W'(quiet), 1);
    endtask

    // Compare logged commands and beats against the pushed order.
    task automatic check_streams(input string tag);
        int ri = 0;
        int wi = 0;
        foreach (cmd_log[i]) begin
            if (cmd_log[i].cmd == CMD_RD) begin
                if (ri < rexp.size()) check_eq({tag, " rd addr"}, DATA_W'(cmd_log[i].addr), DATA_W'(rexp[ri]));
                ri++;
            end else begin
                check_eq({tag, " wr cmd"}, DATA_W'(cmd_log[i].cmd), DATA_W'(CMD_WR));
                if (wi < wexp.size()) check_eq({tag, " wr addr"}, DATA_W'(cmd_log[i].addr), DATA_W'(wexp[wi]));
                wi++;
            end
        end
        check_eq({tag, " n rd"}, DATA_W'(ri), DATA_W'(rexp.size()));
        check_eq({tag, " n wr"}, DATA_W'(wi), DATA_W'(wexp.size()));
        check_eq({tag, " n beats"}, DATA_W'(wdf_log.size()), DATA_W'(dexp.size()));
        foreach (wdf_log[i]) begin
            if (i < dexp.size()) check_eq({tag, " beat data"}, wdf_log[i].data, dexp[i]);
            check_eq({tag, " beat end"}, DATA_W'(wdf_log[i].last), DATA_W'(i % 2));
        end
    endtask

    function automatic int first_wr();
        int idx = -1;
        foreach (cmd_log[i]) if (idx < 0 && cmd_log[i].cmd == CMD_WR) idx = i;
        return idx;
    endfunction

    int widx;
    int exp_len[5] = '{64, 64, 64, 6, 12};
    logic [2:0] exp_dir[5] = '{CMD_WR, CMD_RD, CMD_WR, CMD_RD, CMD_WR};

    initial begin
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
        rdata_fifo_afull = 1'b0; wdata_fifo_rdepth = '0;
        repeat (3) tick();

        // reset state
        check_eq("rst app_en", DATA_W'(app_en), 0);
        check_eq("rst app_cmd", DATA_W'(app_cmd), 0);
        check_eq("rst app_addr", DATA_W'(app_addr), 0);
        check_eq("rst raddr_rd_en", DATA_W'(raddr_fifo_rd_en), 0);
        check_eq("rst waddr_rd_en", DATA_W'(waddr_fifo_rd_en), 0);
        check_eq("rst wdf_wren", DATA_W'(app_wdf_wren), 0);
        check_eq("rst state", DATA_W'(dut.state), DATA_W'(IDLE));
        check_eq("rst credit", DATA_W'(dut.u_wdf.credit), 0);
        check_eq("rst grant", DATA_W'(dut.grant_cnt), 0);
        rst = 1'b0;
        app_rd_data_valid = 1'b1; app_rd_data = {8{32'hC0FFEE01}};
        #1;
        check_eq("rdata wr_en", DATA_W'(rdata_fifo_wr_en), 1);
        check_eq("rdata din", rdata_fifo_din, {8{32'hC0FFEE01}});
        check_eq("wdf mask", DATA_W'(app_wdf_mask), 0);
        app_rd_data_valid = 1'b0;
        tick();

        // reads only: back-to-back, in order, no turnaround
        clear_logs();
        for (int i = 0; i < 10; i++) push_r(32'h100 + i);
        wait_cmds(10, 60, "t1");
        wait_quiet(100, "t1");
        check_streams("t1");
        check_eq("t1 back2back", DATA_W'(cmd_log[9].cyc - cmd_log[0].cyc), 9);
        check_eq("t1 turn cycles", DATA_W'(turn_seen), 0);

        // depth crosses the high mark during reads: 3 dead cycles then one write burst
        clear_logs();
        for (int i = 0; i < 10; i++) push_r(32'h200 + i);
        wait_cmds(3, 40, "t2");
        wdata_fifo_rdepth = 9'd384;
        push_w(32'h1000, 16);
        wait_quiet(200, "t2");
        widx = first_wr();
        check_eq("t2 wr found", DATA_W'(widx > 0), 1);
        if (widx > 0) begin
            check_eq("t2 turn gap", DATA_W'(cmd_log[widx].cyc - cmd_log[widx-1].cyc), 4);
            check_eq("t2 beat0 cyc", DATA_W'(wdf_log[0].cyc - cmd_log[widx].cyc), 1);
        end
        check_eq("t2 turn cycles", DATA_W'(turn_seen), 6);
        check_streams("t2");
        wdata_fifo_rdepth = '0;

        // app_rdy low while a switch is wanted: command held, switch after accept
        clear_logs();
        for (int i = 0; i < 6; i++) push_r(32'h300 + i);
        wait_cmds(2, 40, "t3");
        app_rdy = 1'b0;
        wdata_fifo_rdepth = 9'd384;
        push_w(32'h2000, 32);
        for (int i = 0; i < 5; i++) begin
            #2;
            check_eq("t3 hold en", DATA_W'(app_en), 1);
            check_eq("t3 hold cmd", DATA_W'(app_cmd), DATA_W'(CMD_RD));
            check_eq("t3 hold addr", DATA_W'(app_addr), DATA_W'(rexp[2]));
            check_eq("t3 hold state", DATA_W'(dut.state), DATA_W'(RD));
            tick();
        end
        app_rdy = 1'b1;
        wait_quiet(200, "t3");
        check_eq("t3 stall gap", DATA_W'(cmd_log[2].cyc - cmd_log[1].cyc), 6);
        widx = first_wr();
        check_eq("t3 wr found", DATA_W'(widx > 0), 1);
        if (widx > 0) begin
            check_eq("t3 last rd before turn", DATA_W'(cmd_log[widx-1].addr), DATA_W'(rexp[2]));
            check_eq("t3 turn gap", DATA_W'(cmd_log[widx].cyc - cmd_log[widx-1].cyc), 4);
        end
        check_streams("t3");
        wdata_fifo_rdepth = '0;

        // both sides loaded, depth mid-band: direction flips every 64 commands
        clear_logs();
        wdata_fifo_rdepth = 9'd256;
        for (int i = 0; i < 140; i++) push_w(32'h4000 + i, 100 + i);
        for (int i = 0; i < 70; i++) push_r(32'h8000 + i);
        wait_quiet(3000, "t4");
        run_len.delete(); run_cmd.delete();
        foreach (cmd_log[i]) begin
            if (run_cmd.size() == 0 || run_cmd[run_cmd.size()-1] != cmd_log[i].cmd) begin
                run_cmd.push_back(cmd_log[i].cmd);
                run_len.push_back(1);
            end else begin
                run_len[run_len.size()-1]++;
            end
        end
        check_eq("t4 n runs", DATA_W'(run_len.size()), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < run_len.size()) begin
                check_eq("t4 run len", DATA_W'(run_len[k]), DATA_W'(exp_len[k]));
                check_eq("t4 run dir", DATA_W'(run_cmd[k]), DATA_W'(exp_dir[k]));
            end
        end
        check_streams("t4");

        // wdf stalled: commands stop at full credit, nothing lost
        clear_logs();
        app_wdf_rdy = 1'b0;
        for (int i = 0; i < 10; i++) push_w(32'h6000 + i, 500 + i);
        repeat (20) tick();
        check_eq("t5 cmds at stall", DATA_W'(cmd_log.size()), 4);
        check_eq("t5 credit at stall", DATA_W'(dut.u_wdf.credit), 8);
        check_eq("t5 wren at stall", DATA_W'(app_wdf_wren), 1);
        check_eq("t5 app_en at stall", DATA_W'(app_en), 0);
        check_eq("t5 beats at stall", DATA_W'(wdf_log.size()), 0);
        app_wdf_rdy = 1'b1;
        wait_quiet(300, "t5");
        check_streams("t5");

        // reset in the middle of a write burst
        clear_logs();
        for (int i = 0; i < 4; i++) push_w(32'h7000 + i, 900 + i);
        widx = 0;
        while (wdf_log.size() < 1 && widx < 50) begin
            tick();
            widx++;
        end
        check_eq("t6 first beat seen", DATA_W'(wdf_log.size() >= 1), 1);
        rst = 1'b1;
        rq.delete(); wq.delete(); dq.delete();
        #1;
        check_eq("t6 rst app_en", DATA_W'(app_en), 0);
        check_eq("t6 rst wdf_wren", DATA_W'(app_wdf_wren), 0);
        check_eq("t6 rst wdf_end", DATA_W'(app_wdf_end), 0);
        check_eq("t6 rst waddr_rd_en", DATA_W'(waddr_fifo_rd_en), 0);
        check_eq("t6 rst wdata_rd_en", DATA_W'(wdata_fifo_rd_en), 0);
        check_eq("t6 rst state", DATA_W'(dut.state), DATA_W'(IDLE));
        check_eq("t6 rst credit", DATA_W'(dut.u_wdf.credit), 0);
        check_eq("t6 rst beat_cnt", DATA_W'(dut.u_wdf.beat_cnt), 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check_eq("t6 post state", DATA_W'(dut.state), DATA_W'(IDLE));
        check_eq("t6 post credit", DATA_W'(dut.u_wdf.credit), 0);
        check_eq("t6 post app_en", DATA_W'(app_en), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
